// File: rtl/median_pkg.sv
// Shared constants and configuration checks for the 3x3 median filter.
package median_pkg;

  localparam int MEDIAN_LATENCY = 3;
  localparam int WINDOW_SIZE    = 3;
  localparam int MIN_DIM        = 3;

  function automatic bit dims_legal(int w, int h);
    return (w >= MIN_DIM) && (h >= MIN_DIM);
  endfunction

endpackage

// File: rtl/median_window_filter_sort3.sv
// Combinational 3-input sorter from three compare-exchanges.
module sort3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] lo,
  output logic [W-1:0] mid,
  output logic [W-1:0] hi
);

  logic [W-1:0] x_lo;
  logic [W-1:0] x_hi;
  logic [W-1:0] y_lo;

  always_comb begin
    x_lo = (a < b) ? a : b;
    x_hi = (a < b) ? b : a;
    y_lo = (x_hi < c) ? x_hi : c;
    hi   = (x_hi < c) ? c : x_hi;
    lo   = (x_lo < y_lo) ? x_lo : y_lo;
    mid  = (x_lo < y_lo) ? y_lo : x_lo;
  end

endmodule

// File: rtl/median_window_filter.sv
// Streaming 3x3 median filter: line buffers, window register and
// a three-stage median network emitting one result per interior pixel.
module median_window_filter #(
  parameter int WINDOW_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int PIXEL_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pixel_valid,
  input  logic [PIXEL_WIDTH-1:0] pixel_data,
  output logic                   filtered_valid,
  output logic [PIXEL_WIDTH-1:0] filtered_data,
  output logic                   frame_done
);
  import median_pkg::*;

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int PW = PIXEL_WIDTH;

  typedef logic [PW-1:0] pix_t;

  if (WINDOW_SIZE != median_pkg::WINDOW_SIZE ||
      !dims_legal(IMAGE_WIDTH, IMAGE_HEIGHT)) begin : g_bad_cfg
    $error("median_window_filter: illegal configuration");
  end

  function automatic pix_t max2(pix_t a, pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min2(pix_t a, pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t med3(pix_t a, pix_t b, pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pixel_valid) begin
      if (col_q == CW'(IMAGE_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMAGE_HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Line buffers hold the two previous rows; never reset.
  pix_t lb0_q [IMAGE_WIDTH];
  pix_t lb1_q [IMAGE_WIDTH];

  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pixel_data;
    end
  end

  // Window row 0 is the oldest row, column 2 the newest pixel.
  pix_t win_q [3][3];
  pix_t win_d [3][3];
  logic v0_d, l0_d;

  always_comb begin
    win_d = win_q;
    if (pixel_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_q[col_q];
      win_d[1][2] = lb0_q[col_q];
      win_d[2][2] = pixel_data;
    end
    v0_d = pixel_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));
    l0_d = v0_d && (row_q == RW'(IMAGE_HEIGHT - 1)) &&
           (col_q == CW'(IMAGE_WIDTH - 1));
  end

  pix_t s1_lo_d [3];
  pix_t s1_md_d [3];
  pix_t s1_hi_d [3];

  for (genvar i = 0; i < 3; i++) begin : g_row
    sort3 #(.W(PW)) u_sort (
      .a   (win_q[i][0]),
      .b   (win_q[i][1]),
      .c   (win_q[i][2]),
      .lo  (s1_lo_d[i]),
      .mid (s1_md_d[i]),
      .hi  (s1_hi_d[i])
    );
  end

  logic v0_q, l0_q, v1_q, l1_q, v2_q, l2_q;
  pix_t s1_lo_q [3];
  pix_t s1_md_q [3];
  pix_t s1_hi_q [3];
  pix_t s2_a_q, s2_b_q, s2_c_q;
  pix_t s2_a_d, s2_b_d, s2_c_d;
  logic fv_q, fd_q;
  pix_t fdata_q, fdata_d;

  always_comb begin
    s2_a_d = max2(max2(s1_lo_q[0], s1_lo_q[1]), s1_lo_q[2]);
    s2_b_d = med3(s1_md_q[0], s1_md_q[1], s1_md_q[2]);
    s2_c_d = min2(min2(s1_hi_q[0], s1_hi_q[1]), s1_hi_q[2]);
    fdata_d = fdata_q;
    if (v2_q) fdata_d = med3(s2_a_q, s2_b_q, s2_c_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      v0_q    <= 1'b0;
      l0_q    <= 1'b0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      v2_q    <= 1'b0;
      l2_q    <= 1'b0;
      fv_q    <= 1'b0;
      fd_q    <= 1'b0;
      fdata_q <= '0;
      s2_a_q  <= '0;
      s2_b_q  <= '0;
      s2_c_q  <= '0;
      for (int r = 0; r < 3; r++) begin
        s1_lo_q[r] <= '0;
        s1_md_q[r] <= '0;
        s1_hi_q[r] <= '0;
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      v0_q    <= v0_d;
      l0_q    <= l0_d;
      v1_q    <= v0_q;
      l1_q    <= l0_q;
      s1_lo_q <= s1_lo_d;
      s1_md_q <= s1_md_d;
      s1_hi_q <= s1_hi_d;
      v2_q    <= v1_q;
      l2_q    <= l1_q;
      s2_a_q  <= s2_a_d;
      s2_b_q  <= s2_b_d;
      s2_c_q  <= s2_c_d;
      fv_q    <= v2_q;
      fd_q    <= l2_q;
      fdata_q <= fdata_d;
    end
  end

  assign filtered_valid = fv_q;
  assign filtered_data  = fdata_q;
  assign frame_done     = fd_q;

endmodule

// File: doc/median_window_filter.md
# median_window_filter

Streaming 3x3 median filter that takes a raster-order pixel stream and emits one median-filtered pixel for every interior position of the frame, in raster order. It sits directly upstream of the zero-edge handler and drives that block's `filtered_valid` / `filtered_data` inputs. The block uses two line buffers to form the window, a 3x3 window register and a fixed-latency pipelined median network. It has no backpressure.

## Interface
- `WINDOW_SIZE`, 3: window edge; only 3 is legal and elaboration fails otherwise.
- `IMAGE_WIDTH`, 8: pixels per row, >= 3.
- `IMAGE_HEIGHT`, 8: rows per frame, >= 3.
- `PIXEL_WIDTH`, 8: bits per pixel.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pixel_valid`  in  1  input pixel qualifier; one pixel per high cycle.
- `pixel_data`  in  PIXEL_WIDTH  input pixel, raster order, row 0 col 0 first.
- `filtered_valid`  out  1  one-cycle pulse per median output.
- `filtered_data`  out  PIXEL_WIDTH  median of the 3x3 window; held between pulses.
- `frame_done`  out  1  one-cycle pulse coincident with the last median of a frame.

## Operation
- Position counters `col`, `row` are each $clog2 of their dimension wide. They advance only on `pixel_valid`.
  - `col` wraps at IMAGE_WIDTH-1 and increments `row`.
  - `row` wraps at IMAGE_HEIGHT-1. The frame boundary is implicit: the pixel after (H-1, W-1) is (0, 0) of the next frame.
- Line buffers `lb0` and `lb1` are each IMAGE_WIDTH x PIXEL_WIDTH. On a valid pixel at column c:
  - read `lb1[c]`, `lb0[c]`;
  - write `lb1[c] <= lb0[c]` and `lb0[c] <= pixel_data`.
- Window: nine registers. On a valid pixel, columns shift left and the new right column is {`lb1[c]` (top), `lb0[c]` (middle), `pixel_data` (bottom)}.
- Window completion: a valid pixel at (r, c) with r >= 2 and c >= 2 completes the window centred on (r-1, c-1). This tag enters the pipeline.
  - Exactly (W-2)*(H-2) tags are produced per frame.
  - Windows with c < 2 straddle rows or stale columns. They are never tagged, so no masking is needed.
- Median pipeline: three register stages, each carrying a valid tag and a last tag. The pipeline advances every clock, independent of `pixel_valid`.
  - S1: sort each window row (3 sorters) into min, med, max.
  - S2: compute max of the three mins, median of the three meds, and min of the three maxes.
  - S3: the median of those three values is registered into `filtered_data`.
- The last tag is set for the window completed by pixel (H-1, W-1). It drives `frame_done`.
- All arithmetic is unsigned compare only; there is no width growth.
- Line buffer contents are never reset. A stale-row read is impossible because r >= 2 gates emission.

## Timing
- Reset values:
  - `filtered_valid` = 0, `filtered_data` = 0, `frame_done` = 0.
  - Counters = 0 and all pipeline tags = 0.
  - Window registers = 0. Line buffers are not reset.
- Latency: a completing pixel sampled at edge k produces `filtered_valid` high for the cycle after edge k+3. This is fixed at 3 clocks, regardless of input gaps.
- Back-to-back `pixel_valid` (1 pixel/clk) is fully supported. Arbitrary gaps are allowed; output spacing mirrors the input spacing.
- `frame_done` is high in the same cycle as the final `filtered_valid` of the frame and never at any other time.
- Frames may be back-to-back with no idle cycle. Pixel (0, 0) of frame n+1 may arrive while frame n's last median is still in the pipeline; the two do not interact.
- Reset mid-frame:
  - asynchronously clears counters, tags and outputs;
  - in-flight medians are discarded;
  - the next valid pixel is treated as (0, 0).

## Structure
- Package `median_pkg` holds `MEDIAN_LATENCY` = 3, `WINDOW_SIZE` = 3, and the legality checks on IMAGE_WIDTH/HEIGHT.
- One sub-module: `sort3`, a combinational 3-input sorter (min, med, max) built from three compare-exchanges. It is instanced 3x in S1, and its outputs are reused in S2/S3.
- Line buffers are plain register arrays, or an inferred single-port RAM with read-before-write.

## Test plan
- 8x8 frame, every pixel 50, valid every cycle -> 36 pulses, all data 50; `frame_done` on the 36th only.
- 8x8 ramp, pixel = row*8+col -> outputs equal the centre value:
  - first output 9, last 54;
  - first pulse 3 clks after pixel (2, 2) is sampled.
- All-zero frame with 255 at (3, 3) (impulse) -> all 36 outputs 0.
- Ramp frame with random 0–3 cycle gaps in `pixel_valid` -> the same 36 values as the gapless run, with each output exactly 3 clks after its completing pixel.
- Reset asserted after pixel (4, 5), then a fresh full ramp frame -> no pulses from the aborted frame; the full 9..54 sequence with a single `frame_done`.
- Two back-to-back frames (ramp, then constant 7) -> 36 ramp values, `frame_done`, then 36 values of 7 and a second `frame_done`.
